// File: rtl/float_pack.sv
// Shared float format, constants and helpers for the coprocessor arithmetic units.
// FLOAT_DIV_ROUND_EN selects one extra divider step that yields a guard bit.
package float_pack;

    localparam int Nm   = 23;
    localparam int Ne   = 8;
    localparam int De   = 2**(Ne-1) - 1;
    localparam int EMAX = 2**Ne - 2;

`ifdef FLOAT_DIV_ROUND_EN
    localparam int QW = Nm + 3;
`else
    localparam int QW = Nm + 2;
`endif

    typedef struct packed {
        logic          s;
        logic [Ne-1:0] e;
        logic [Nm-1:0] m;
    } float;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SPECIAL = 3'd1,
        DIV     = 3'd2,
        NORM    = 3'd3,
        DONE    = 3'd4
    } fdiv_state_t;

    function automatic float float_zero(input logic s);
        float f;
        f.s = s;
        f.e = '0;
        f.m = '0;
        return f;
    endfunction

    function automatic float float_sat(input logic s);
        float f;
        f.s = s;
        f.e = Ne'(EMAX);
        f.m = '1;
        return f;
    endfunction

endpackage

// File: rtl/float_div_seq_if.sv
// start/done operation handshake between the coprocessor sequencer and the divider.
interface float_div_seq_if;
    logic             start;
    float_pack::float a;
    float_pack::float b;
    logic             ready;
    logic             done;
    float_pack::float result;
    logic             div_by_zero;

    modport master (output start, a, b, input ready, done, result, div_by_zero);
    modport slave  (input start, a, b, output ready, done, result, div_by_zero);
endinterface

// File: rtl/mant_div_iter.sv
// Restoring mantissa divider: one quotient bit per clock, N steps after load.
module mant_div_iter #(
    parameter int W = 25,
    parameter int N = 25
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] rem_init,
    input  logic [W-1:0] div_init,
    output logic         busy,
    output logic [N-1:0] q
);
    localparam int CW = $clog2(N + 1);

    logic [W-1:0]  rem_q, rem_d, div_q, div_d, diff_s;
    logic [N-1:0]  q_q, q_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          run_q, run_d, ge_s;

    // Next-state for the shift registers and step counter.
    always_comb begin
        rem_d  = rem_q;
        div_d  = div_q;
        q_d    = q_q;
        cnt_d  = cnt_q;
        run_d  = run_q;
        ge_s   = (rem_q >= div_q);
        diff_s = ge_s ? (rem_q - div_q) : rem_q;
        if (load) begin
            rem_d = rem_init;
            div_d = div_init;
            q_d   = '0;
            cnt_d = CW'(N - 1);
            run_d = 1'b1;
        end else if (run_q) begin
            // diff < div < 2**(W-1), so the shifted-out bit is always zero
            rem_d = {diff_s[W-2:0], 1'b0};
            q_d   = {q_q[N-2:0], ge_s};
            if (cnt_q == '0) begin
                run_d = 1'b0;
            end else begin
                cnt_d = cnt_q - CW'(1);
            end
        end else begin
            run_d = 1'b0;
        end
    end

    // Divider state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rem_q <= '0;
            div_q <= '0;
            q_q   <= '0;
            cnt_q <= '0;
            run_q <= 1'b0;
        end else begin
            rem_q <= rem_d;
            div_q <= div_d;
            q_q   <= q_d;
            cnt_q <= cnt_d;
            run_q <= run_d;
        end
    end

    // busy drops during the final step so the caller leaves on the same edge.
    assign busy = run_q && (cnt_q != '0);
    assign q    = q_q;

endmodule

// File: rtl/float_div_seq.sv
// Sequential float divider a / b behind the start/done handshake.
// Define FLOAT_DIV_ROUND_EN for round-half-up via a guard bit (one extra cycle).
module float_div_seq
    import float_pack::*;
(
    input  logic           clk,
    input  logic           reset,
    float_div_seq_if.slave bus
);
    fdiv_state_t   state_q, state_d;
    logic          sgn_q, sgn_d, dbz_q, dbz_d;
    logic [Ne-1:0] ea_q, ea_d, eb_q, eb_d;
    float          res_q, res_d, result_q, result_d, norm_res_s;
    logic          div_by_zero_q, div_by_zero_d, done_q, done_d, ready_q, ready_d;
    logic          load_s, busy_s;
    logic [QW-1:0] q_s;
    logic [Ne+1:0] ex_s;
    logic [Nm-1:0] mant_s;
`ifdef FLOAT_DIV_ROUND_EN
    logic          carry_s;
`endif

    mant_div_iter #(.W(Nm + 2), .N(QW)) u_iter (
        .clk      (clk),
        .reset    (reset),
        .load     (load_s),
        .rem_init ({2'b01, bus.a.m}),
        .div_init ({2'b01, bus.b.m}),
        .busy     (busy_s),
        .q        (q_s)
    );

    // Exponent arithmetic, normalisation and range clamping of the quotient.
    always_comb begin
        ex_s = {2'b00, ea_q} - {2'b00, eb_q} + (Ne+2)'(De);
`ifdef FLOAT_DIV_ROUND_EN
        if (q_s[Nm+2]) begin
            {carry_s, mant_s} = {1'b0, q_s[Nm+1:2]} + {{Nm{1'b0}}, q_s[1]};
        end else begin
            {carry_s, mant_s} = {1'b0, q_s[Nm:1]} + {{Nm{1'b0}}, q_s[0]};
            ex_s = ex_s - (Ne+2)'(1);
        end
        if (carry_s) begin
            ex_s = ex_s + (Ne+2)'(1);
        end else begin
            ex_s = ex_s;
        end
`else
        if (q_s[Nm+1]) begin
            mant_s = q_s[Nm:1];
        end else begin
            mant_s = q_s[Nm-1:0];
            ex_s   = ex_s - (Ne+2)'(1);
        end
`endif
        if (ex_s[Ne+1] || (ex_s == '0)) begin
            norm_res_s = float_zero(sgn_q);
        end else if (ex_s[Ne:0] > (Ne+1)'(EMAX)) begin
            norm_res_s = float_sat(sgn_q);
        end else begin
            norm_res_s = {sgn_q, ex_s[Ne-1:0], mant_s};
        end
    end

    // FSM next state and output register inputs.
    always_comb begin
        state_d       = state_q;
        sgn_d         = sgn_q;
        ea_d          = ea_q;
        eb_d          = eb_q;
        res_d         = res_q;
        dbz_d         = dbz_q;
        result_d      = result_q;
        div_by_zero_d = div_by_zero_q;
        done_d        = 1'b0;
        load_s        = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    sgn_d = bus.a.s ^ bus.b.s;
                    ea_d  = bus.a.e;
                    eb_d  = bus.b.e;
                    if ((bus.a.e == '0) || (bus.b.e == '0)) begin
                        state_d = SPECIAL;
                    end else begin
                        state_d = DIV;
                        load_s  = 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            SPECIAL: begin
                // Zero divisor wins, so 0/0 saturates with the flag set.
                if (eb_q == '0) begin
                    res_d = float_sat(sgn_q);
                    dbz_d = 1'b1;
                end else begin
                    res_d = float_zero(sgn_q);
                    dbz_d = 1'b0;
                end
                state_d = DONE;
            end
            DIV: begin
                if (!busy_s) begin
                    state_d = NORM;
                end else begin
                    state_d = DIV;
                end
            end
            NORM: begin
                res_d   = norm_res_s;
                dbz_d   = 1'b0;
                state_d = DONE;
            end
            DONE: begin
                result_d      = res_q;
                div_by_zero_d = dbz_q;
                done_d        = 1'b1;
                state_d       = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        ready_d = (state_d == IDLE);
    end

    // State, operand and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            sgn_q         <= 1'b0;
            ea_q          <= '0;
            eb_q          <= '0;
            res_q         <= '0;
            dbz_q         <= 1'b0;
            result_q      <= '0;
            div_by_zero_q <= 1'b0;
            done_q        <= 1'b0;
            ready_q       <= 1'b1;
        end else begin
            state_q       <= state_d;
            sgn_q         <= sgn_d;
            ea_q          <= ea_d;
            eb_q          <= eb_d;
            res_q         <= res_d;
            dbz_q         <= dbz_d;
            result_q      <= result_d;
            div_by_zero_q <= div_by_zero_d;
            done_q        <= done_d;
            ready_q       <= ready_d;
        end
    end

    assign bus.ready       = ready_q;
    assign bus.done        = done_q;
    assign bus.result      = result_q;
    assign bus.div_by_zero = div_by_zero_q;

endmodule

// File: tb/tb_float_div_seq.sv
// Randomised scoreboard bench for float_div_seq against an arithmetic reference model.
module tb_float_div_seq;
    import float_pack::*;

`ifdef FLOAT_DIV_ROUND_EN
    localparam int G = 1;
`else
    localparam int G = 0;
`endif
    localparam int NORM_LAT = Nm + 4 + G;

    typedef struct {
        logic [31:0] res;
        logic        dbz;
        int          lat;
        int          t0;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    float_div_seq_if bus();

    float_div_seq dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    // Quotient from exact integer division of the significands.
    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic dbz, output int lat);
        logic   s;
        int     ea, eb, e;
        longint sa, sbv, q, sig;
        s   = a[31] ^ b[31];
        ea  = int'(a[30:23]);
        eb  = int'(b[30:23]);
        dbz = 1'b0;
        lat = 2;
        if (eb == 0) begin
            r   = {s, 8'hFE, 23'h7FFFFF};
            dbz = 1'b1;
        end else if (ea == 0) begin
            r = {s, 31'd0};
        end else begin
            sa  = (64'd1 << 23) + longint'(a[22:0]);
            sbv = (64'd1 << 23) + longint'(b[22:0]);
            q   = (sa << (24 + G)) / sbv;
            e   = ea - eb + 127;
            if (q >= (64'd1 << (24 + G))) begin
                sig = q >> 1;
            end else begin
                sig = q;
                e   = e - 1;
            end
            if (G == 1) begin
                sig = (sig + 64'd1) >> 1;
                if (sig == (64'd1 << 24)) begin
                    sig = sig >> 1;
                    e   = e + 1;
                end
            end
            if (e <= 0)        r = {s, 31'd0};
            else if (e > 254)  r = {s, 8'hFE, 23'h7FFFFF};
            else               r = {s, 8'(e), 23'(sig)};
            lat = NORM_LAT;
        end
    endfunction

    // Monitor: every done pulse is matched against the oldest expectation.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!reset && bus.done === 1'b1) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_done: got done=1 required no pending op (t=%0t)", $time);
            end else begin
                e = sb.pop_front();
                check("result", bus.result, e.res);
                check("div_by_zero", 32'(bus.div_by_zero), 32'(e.dbz));
                check("latency", 32'(cyc - e.t0), 32'(e.lat));
            end
        end
    end

    task automatic issue(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] r, input logic dbz, input int lat);
        int k = 0;
        while (bus.ready !== 1'b1 && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (k >= 100) begin
            n_cmp++;
            n_bad++;
            $display("FAIL ready_timeout: got ready=%b required 1", bus.ready);
        end
        sb.push_back('{r, dbz, lat, cyc + 1});
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        @(negedge clk);
        bus.start = 1'b0;
        bus.a     = $urandom;
        bus.b     = $urandom;
    endtask

    task automatic wait_done();
        int k = 0;
        while (bus.done !== 1'b1 && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (k >= 100) begin
            n_cmp++;
            n_bad++;
            $display("FAIL done_timeout: got no done in %0d cycles required one", k);
        end
        @(negedge clk);
    endtask

    function automatic int lat_of(input logic [31:0] a, input logic [31:0] b);
        return (a[30:23] == 8'd0 || b[30:23] == 8'd0) ? 2 : NORM_LAT;
    endfunction

    task automatic run_c(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] r, input logic dbz);
        issue(a, b, r, dbz, lat_of(a, b));
        wait_done();
    endtask

    task automatic run_m(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        logic        dbz;
        int          lat;
        model(a, b, r, dbz, lat);
        issue(a, b, r, dbz, lat);
        wait_done();
    endtask

    initial begin
        logic [31:0] ra, rb;
        int          kind;
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_ready", 32'(bus.ready), 32'd1);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_result", bus.result, 32'd0);
        check("rst_dbz", 32'(bus.div_by_zero), 32'd0);

        run_c(32'h40C00000, 32'h40000000, 32'h40400000, 1'b0);
`ifdef FLOAT_DIV_ROUND_EN
        run_c(32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 1'b0);
`else
        run_c(32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 1'b0);
`endif
        run_c(32'hBF800000, 32'h40800000, 32'hBE800000, 1'b0);
        run_c(32'h00000000, 32'h40E00000, 32'h00000000, 1'b0);
        run_c(32'h71800000, 32'h0D800000, 32'h7F7FFFFF, 1'b0);
        run_c(32'h0D800000, 32'h71800000, 32'h00000000, 1'b0);
        run_c(32'h3FC00000, 32'h3FC00000, 32'h3F800000, 1'b0);
        run_c(32'h00000000, 32'h00000000, 32'h7F7FFFFF, 1'b1);
        run_c(32'h40A00000, 32'h00000000, 32'h7F7FFFFF, 1'b1);

        // Abort mid-divide: outputs fall back to reset values at once.
        bus.start = 1'b1;
        bus.a     = 32'h40C00000;
        bus.b     = 32'h40000000;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (11) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("abort_ready", 32'(bus.ready), 32'd1);
        check("abort_done", 32'(bus.done), 32'd0);
        check("abort_result", bus.result, 32'd0);
        check("abort_dbz", 32'(bus.div_by_zero), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (35) @(negedge clk);
        run_c(32'h40C00000, 32'h40000000, 32'h40400000, 1'b0);

        // Start pulses while busy must be dropped.
        issue(32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, NORM_LAT);
        for (int i = 1; i <= 12; i++) begin
            if (i == 3 || i == 10) begin
                check("busy_ready", 32'(bus.ready), 32'd0);
                bus.start = 1'b1;
                bus.a     = 32'h40A00000;
                bus.b     = 32'h00000000;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
        end
        bus.start = 1'b0;
        wait_done();

        for (int n = 0; n < 40; n++) begin
            kind = int'($urandom_range(0, 9));
            ra   = {1'($urandom), 8'($urandom_range(1, 254)), 23'($urandom)};
            rb   = {1'($urandom), 8'($urandom_range(1, 254)), 23'($urandom)};
            if (kind == 0) ra[30:23] = 8'd0;
            if (kind == 1) rb[30:23] = 8'd0;
            run_m(ra, rb);
        end

        repeat (5) @(negedge clk);
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
